demux18_deser: RTL

- Serial-to-parallel receiver and 1:8 demultiplexer. It is the receive-side counterpart of the 8:1 select mux.
- A single serial bit stream is steered, one bit per accepted beat, into lane S of a WIDTH-bit word. An internal lane counter generates S.
- A completed word is handed off through a one-entry output buffer with a valid/ready handshake.
- Sits between a serial link or mux output and any parallel consumer (register file load path, debug port).

---
 rtl/demux18_deser.sv | 63 ++++++
 1 files changed

// File: rtl/demux18_deser.sv
// demux18_deser: serial-to-parallel 1:WIDTH demux with lane counter and one-entry valid/ready output buffer
module demux18_deser #(
    parameter int WIDTH = 8,
    parameter bit LSB_FIRST = 1,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             start,
    output logic             in_ready,
    output logic [WIDTH-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] S,
    output logic             frame_err
);
    typedef enum logic {IDLE, COLLECT} state_t;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    state_t state, state_nx;
    logic [WIDTH-1:0] shreg, word;
    logic [SEL_W-1:0] lane, idx;
    logic accept, complete;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = accept ? (complete ? IDLE : COLLECT) : state;
    end

    // start restarts the frame: the bit goes to lane 0 over a cleared word
    always_comb begin
        in_ready = !(S == LAST && out_valid && !out_ready);
        accept = in_valid && in_ready;
        lane = start ? '0 : S;
        idx = LSB_FIRST ? lane : LAST - lane;
        word = (start ? '0 : shreg) | (WIDTH'(in) << idx);
        complete = accept && lane == LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            S <= '0;
            shreg <= '0;
            D <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                S <= complete ? '0 : lane + 1'b1;
                shreg <= complete ? '0 : word;
                frame_err <= frame_err | (start && state == COLLECT);
            end
            if (complete) D <= word;
            out_valid <= complete | (out_valid & !out_ready);
        end
    end
endmodule
